grid_pixel_gen: RTL
===================

Name: grid_pixel_gen

Overview:
- Parametrised successor to the fixed 4x4 board pixel generator.
- Maps the VGA raster onto a ROWS x COLS grid of cells and colours each cell from a packed 2-bit-per-cell board vector.
- Checkerboards empty cells and overlays a blinking cursor. Output is registered with fixed latency and gated by a pipelined video_on.
- Sits between the VGA sync controller and the DAC pins, driven by game-logic board state.

Parameters:
- COLS, 4, grid columns (1..8).
- ROWS, 4, grid rows (1..8).
- CELL_W, 160, cell width in pixels.
- CELL_H, 120, cell height in pixels.
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1).
- LINE_W, 2, grid line thickness in pixels (used only with GRID_LINES_EN).

Ports:
- clk_d  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pixel_x  in  10  current column from the sync controller
- pixel_y  in  10  current row from the sync controller
- video_on  in  1  active-video flag, aligned with pixel_x/pixel_y
- board  in  2*ROWS*COLS  cell i = board[2i+1:2i], i = row*COLS+col
- select_position  in  $clog2(ROWS*COLS) (min 1)  cursor cell index
- cursor_en  in  1  enables the cursor overlay
- red  out  4  colour output
- green  out  4  colour output
- blue  out  4  colour output

Behaviour:
- One clock, clk_d. Reset is synchronous and active-high.
- Reset values:
  - red, green, blue = 0.
  - All pipeline registers = 0; video_on pipe = 0.
  - Frame counter = 0; blink_phase = 1 (cursor visible).
- Latency: 2 clk_d from pixel_x/pixel_y/video_on to red/green/blue. video_on is delayed 2 stages alongside the data.
- Stage 1 (registered):
  - col = count of k in 1..COLS-1 with pixel_x >= k*CELL_W.
  - row = same computation with pixel_y and CELL_H.
  - in_grid = (pixel_x < COLS*CELL_W) && (pixel_y < ROWS*CELL_H).
  - x_off = pixel_x - col*CELL_W; y_off = pixel_y - row*CELL_H.
  - No dividers are used.
- Stage 2 (registered), colour priority from highest to lowest:
  1. video_on_d2 == 0 -> 000.
  2. !in_grid -> 000.
  3. Cursor: cursor_en && blink_phase && idx == select_position -> blue F, others 0.
  4. Cell state 01 -> green F. State 10 -> red F. State 11 -> red F + green F (yellow).
  5. State 00 -> checkerboard: (row+col) even = white FFF, odd = black 000.
- board and select_position are sampled live at stage 2; no internal board copy is kept.
- select_position >= ROWS*COLS -> no cursor is drawn.
- When the cursor is drawn on an occupied cell, the cursor wins while blink_phase = 1; the cell colour shows while blink_phase = 0.
- Frame-start detection:
  - fs = (pixel_x == 0 && pixel_y == 0) && !fs_prev.
  - One pulse per frame, even if the raster dwells several clocks at the origin.
- Blink timer:
  - On fs, frame_cnt increments.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - Runs regardless of cursor_en.
- Reset mid-frame: outputs are 0 the cycle after reset is asserted. The first valid pixel appears 2 cycles after reset deasserts. The blink timer restarts at 0 with phase 1.
- Arithmetic: index math is unsigned, width $clog2(ROWS*COLS). Offsets are 10 bits.

Optional Feature:
- Macro: GRID_LINES_EN.
- Defined: inside the grid, pixels with x_off < LINE_W or y_off < LINE_W, plus the last LINE_W pixels before the right and bottom grid edges, output grey 888. Priority: below video_on/in_grid, above the cursor and cell colours.
- Undefined: no lines; cells abut directly. LINE_W is ignored.

Decomposition:
- Shared package vga_grid_pkg holds:
  - Cell-state encodings: EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10, BOTH = 2'b11.
  - 12-bit colour constants: BLACK, WHITE, GREEN, RED, YELLOW, BLUE, GREY.
  - H_ACTIVE = 640, V_ACTIVE = 480.
- Sub-module grid_blink_timer contains:
  - the frame-start edge detector;
  - frame_cnt and blink_phase;
  - output blink_phase, parameter BLINK_FRAMES.

Test Plan:
- Default params, board = 0, cursor_en = 0; drive pixel (0,0), then (200,0), with video_on = 1 -> 2 cycles later RGB = FFF, then 000 (checkerboard).
- board cell 5 = 01, cell 6 = 10, cell 15 = 11; pixels (170,130), (330,130), (600,400) -> RGB = 0F0, F00, FF0.
- cursor_en = 1, select_position = 5, BLINK_FRAMES = 2; run 4 frames sampling (170,130) -> blue 00F for frames 0-1, green 0F0 for frames 2-3, blue again at frame 4.
- video_on = 0 at pixel (10,10) with cell 0 = 10 -> RGB = 000. Hold (0,0) for 5 clocks -> frame_cnt increments exactly once.
- COLS = 3, ROWS = 2, CELL_W = 100; pixel (350,50) -> 000 (outside grid). select_position = 7 -> no blue anywhere.
- Assert reset at pixel (170,130) mid-frame -> RGB = 000 the next cycle. Deassert -> correct colour after 2 cycles, blink_phase = 1. With GRID_LINES_EN, pixel (160,50) -> 888.

Source files
------------

// File: rtl/vga_grid_pkg.sv
// Shared definitions for the grid pixel generator: cell-state encodings, 12-bit RGB
// colour constants, active-video geometry and the cell colouring helper.
package vga_grid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10,
        BOTH  = 2'b11
    } cell_state_t;

    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] YELLOW = 12'hFF0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] GREY   = 12'h888;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Empty cells fall back to a checkerboard keyed on (row + col) parity.
    function automatic logic [11:0] cell_colour(input cell_state_t st, input logic parity_odd);
        case (st)
            P1:      return GREEN;
            P2:      return RED;
            BOTH:    return YELLOW;
            default: return parity_odd ? BLACK : WHITE;
        endcase
    endfunction

endpackage

// File: rtl/grid_blink_timer.sv
// Cursor blink timer: one frame-start pulse per visit to the raster origin, counted
// modulo BLINK_FRAMES; blink_phase toggles on each wrap and resets to visible.
module grid_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk_d,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       blink_phase
);

    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic           w_at_origin;
    logic           w_fs;
    logic           r_fs_prev;
    logic           r_blink_phase;
    logic [FCW-1:0] r_frame_cnt;

    // Dwelling at the origin for several clocks still yields a single pulse.
    assign w_at_origin = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    assign w_fs        = w_at_origin && !r_fs_prev;

    always_ff @(posedge clk_d) begin
        if (reset) begin
            r_fs_prev     <= 1'b0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else begin
            r_fs_prev <= w_at_origin;
            if (w_fs) begin
                if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FCW'(1);
                end
            end
        end
    end

    assign blink_phase = r_blink_phase;

endmodule

// File: rtl/grid_pixel_gen.sv
// Grid pixel generator: maps the raster onto a ROWS x COLS board, 2-cycle RGB latency.
// Optional macro GRID_LINES_EN draws grey grid lines LINE_W pixels thick.
module grid_pixel_gen
    import vga_grid_pkg::*;
#(
    parameter int COLS         = 4,
    parameter int ROWS         = 4,
    parameter int CELL_W       = 160,
    parameter int CELL_H       = 120,
    parameter int BLINK_FRAMES = 30,
    parameter int LINE_W       = 2
) (
    input  logic                                                clk_d,
    input  logic                                                reset,
    input  logic [9:0]                                          pixel_x,
    input  logic [9:0]                                          pixel_y,
    input  logic                                                video_on,
    input  logic [2*ROWS*COLS-1:0]                              board,
    input  logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] select_position,
    input  logic                                                cursor_en,
    output logic [3:0]                                          red,
    output logic [3:0]                                          green,
    output logic [3:0]                                          blue
);

    localparam int CELLS = ROWS * COLS;
    localparam int SELW  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

`ifdef GRID_LINES_EN
    localparam bit LINES_ON = 1'b1;
`else
    localparam bit LINES_ON = 1'b0;
`endif

    logic w_blink_phase;

    grid_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_timer (
        .clk_d      (clk_d),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .blink_phase(w_blink_phase)
    );

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [9:0]    w_x_base;
    logic [9:0]    w_y_base;
    logic          w_in_grid;
    logic          w_edge;

    // Cell index by threshold comparison; the highest boundary passed wins.
    always_comb begin
        w_col    = '0;
        w_x_base = '0;
        for (int k = 1; k < COLS; k++) begin
            if (32'(pixel_x) >= 32'(k * CELL_W)) begin
                w_col    = CW'(k);
                w_x_base = 10'(k * CELL_W);
            end
        end
        w_row    = '0;
        w_y_base = '0;
        for (int k = 1; k < ROWS; k++) begin
            if (32'(pixel_y) >= 32'(k * CELL_H)) begin
                w_row    = RW'(k);
                w_y_base = 10'(k * CELL_H);
            end
        end
    end

    assign w_in_grid = (32'(pixel_x) < 32'(COLS * CELL_W)) && (32'(pixel_y) < 32'(ROWS * CELL_H));
    assign w_edge    = (32'(pixel_x) >= 32'(COLS * CELL_W - LINE_W)) ||
                       (32'(pixel_y) >= 32'(ROWS * CELL_H - LINE_W));

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [9:0]    r_x_off;
    logic [9:0]    r_y_off;
    logic          r_in_grid;
    logic          r_edge;
    logic          r_video_on;

    always_ff @(posedge clk_d) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_x_off    <= '0;
            r_y_off    <= '0;
            r_in_grid  <= 1'b0;
            r_edge     <= 1'b0;
            r_video_on <= 1'b0;
        end else begin
            r_col      <= w_col;
            r_row      <= w_row;
            r_x_off    <= pixel_x - w_x_base;
            r_y_off    <= pixel_y - w_y_base;
            r_in_grid  <= w_in_grid;
            r_edge     <= w_edge;
            r_video_on <= video_on;
        end
    end

    logic [1:0] w_cell [CELLS];

    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
        assign w_cell[gi] = board[2*gi+1 : 2*gi];
    end

    logic [SELW-1:0] w_idx;
    cell_state_t     w_state;
    logic            w_on_line;
    logic [11:0]     w_rgb_next;
    logic [11:0]     r_rgb;

    // Board and cursor position are sampled live here, one cycle after the pixel.
    always_comb begin
        w_idx   = SELW'(int'(r_row) * COLS + int'(r_col));
        w_state = cell_state_t'(w_cell[0]);
        for (int k = 1; k < CELLS; k++) begin
            if (w_idx == SELW'(k)) begin
                w_state = cell_state_t'(w_cell[k]);
            end
        end
        w_on_line = (r_x_off < 10'(LINE_W)) || (r_y_off < 10'(LINE_W)) || r_edge;

        w_rgb_next = BLACK;
        if (!r_video_on || !r_in_grid) begin
            w_rgb_next = BLACK;
        end else if (LINES_ON && w_on_line) begin
            w_rgb_next = GREY;
        end else if (cursor_en && w_blink_phase && (w_idx == select_position)) begin
            w_rgb_next = BLUE;
        end else begin
            w_rgb_next = cell_colour(w_state, r_row[0] ^ r_col[0]);
        end
    end

    always_ff @(posedge clk_d) begin
        if (reset) begin
            r_rgb <= BLACK;
        end else begin
            r_rgb <= w_rgb_next;
        end
    end

    assign red   = r_rgb[11:8];
    assign green = r_rgb[7:4];
    assign blue  = r_rgb[3:0];

endmodule
